// File: rtl/vga_fetch.sv
// Framebuffer word prefetcher feeding the VGA pixel path over a shared req/gnt/valid read port.
// Optional underrun event counter enabled with `define VGA_FETCH_UNDERRUN_CNT_EN.
module vga_fetch #(
  parameter int DATA_WIDTH              = 16,
  parameter int ADDR_WIDTH              = 8,
  parameter int BITS_PER_MEMORY_PIXEL_X = 3,
  parameter int BITS_PER_MEMORY_PIXEL_Y = 4,
  parameter int HEX_START_X             = 512,
  parameter int AREA_H                  = 384,
  parameter int H_LAST                  = 799,
  parameter int V_LAST                  = 524,
  parameter int BASE_ADDR               = 0
) (
  input  logic                  CLK_50,
  input  logic                  RESET_N,
  input  logic [9:0]            pixel_x,
  input  logic [9:0]            pixel_y,
  output logic                  mem_rd_req,
  output logic [ADDR_WIDTH-1:0] mem_rd_addr,
  input  logic                  mem_rd_gnt,
  input  logic                  mem_rd_valid,
  input  logic [DATA_WIDTH-1:0] mem_rd_data,
  output logic [DATA_WIDTH-1:0] pixel_in,
  output logic                  underrun
`ifdef VGA_FETCH_UNDERRUN_CNT_EN
  ,
  output logic [7:0]            underrun_cnt
`endif
);

  localparam int PPW_LOG2 = $clog2(DATA_WIDTH) + BITS_PER_MEMORY_PIXEL_X;
  localparam int PPW      = 1 << PPW_LOG2;
  localparam int WPR      = HEX_START_X / PPW;
  localparam int COL_W    = $clog2(WPR + 1);

  localparam logic [9:0]            PPW_MASK  = 10'(PPW - 1);
  localparam logic [9:0]            ROW_END_X = 10'(HEX_START_X - 1);
  localparam logic [9:0]            H_LAST_X  = 10'(H_LAST);
  localparam logic [9:0]            V_LAST_Y  = 10'(V_LAST);
  localparam logic [9:0]            AREA_H_Y  = 10'(AREA_H);
  localparam logic [COL_W-1:0]      WPR_C     = COL_W'(WPR);
  localparam logic [ADDR_WIDTH-1:0] BASE_C    = ADDR_WIDTH'(BASE_ADDR);
  localparam logic [ADDR_WIDTH-1:0] WPR_A     = ADDR_WIDTH'(WPR);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_FULL = 2'd3
  } state_t;

  state_t                  state_r, state_nx_s;
  logic                    req_nx_s;
  logic [ADDR_WIDTH-1:0]   addr_nx_s;
  logic                    stale_r, stale_nx_s;
  logic                    buf_ld_s;
  logic [DATA_WIDTH-1:0]   buf_r;
  logic [9:0]              tline_r;
  logic [COL_W-1:0]        tcol_r;
  logic                    pend_r;

  logic [9:0]              nline_s;
  logic [9:0]              mrow_s;
  logic [ADDR_WIDTH-1:0]   tgt_addr_s;
  logic [COL_W-1:0]        col_next_s;
  logic                    col_more_s;
  logic                    word_bnd_s;
  logic                    row_end_s;
  logic                    line_start_s;
  logic                    load_s;
  logic                    full_s;
  logic                    underrun_ev_s;
  logic                    issue_s;

  assign nline_s      = (pixel_y == V_LAST_Y) ? 10'd0 : pixel_y + 10'd1;
  assign mrow_s       = tline_r >> BITS_PER_MEMORY_PIXEL_Y;
  assign tgt_addr_s   = BASE_C + ADDR_WIDTH'(mrow_s) * WPR_A + ADDR_WIDTH'(tcol_r);
  assign col_next_s   = tcol_r + COL_W'(1);
  assign col_more_s   = (col_next_s < WPR_C);

  assign word_bnd_s   = ((pixel_x & PPW_MASK) == PPW_MASK) && (pixel_x < ROW_END_X) &&
                        (pixel_y < AREA_H_Y);
  assign row_end_s    = (pixel_x == ROW_END_X);
  assign line_start_s = (pixel_x == H_LAST_X) && (nline_s < AREA_H_Y);
  assign load_s       = word_bnd_s || line_start_s;
  assign full_s       = (state_r == ST_FULL);
  assign underrun_ev_s = load_s && !full_s;

  // A fetch is never started on a cycle where the target itself is about to move.
  assign issue_s      = (state_r == ST_IDLE) && pend_r && (tline_r < AREA_H_Y) &&
                        !load_s && !row_end_s;

  // Read-port FSM next state and next request/address.
  always_comb begin
    state_nx_s = state_r;
    req_nx_s   = mem_rd_req;
    addr_nx_s  = mem_rd_addr;
    stale_nx_s = stale_r;
    buf_ld_s   = 1'b0;
    case (state_r)
      ST_IDLE: begin
        stale_nx_s = 1'b0;
        if (issue_s) begin
          state_nx_s = ST_REQ;
          req_nx_s   = 1'b1;
          addr_nx_s  = tgt_addr_s;
        end else begin
          state_nx_s = ST_IDLE;
          req_nx_s   = 1'b0;
        end
      end
      ST_REQ: begin
        if (underrun_ev_s) begin
          stale_nx_s = 1'b1;
        end else begin
          stale_nx_s = stale_r;
        end
        if (mem_rd_gnt) begin
          state_nx_s = ST_WAIT;
          req_nx_s   = 1'b0;
        end else begin
          state_nx_s = ST_REQ;
          req_nx_s   = 1'b1;
        end
      end
      ST_WAIT: begin
        req_nx_s = 1'b0;
        if (mem_rd_valid) begin
          stale_nx_s = 1'b0;
          // data arriving with (or after) a missed deadline belongs to a word already shown black
          if (stale_r || underrun_ev_s) begin
            state_nx_s = ST_IDLE;
          end else begin
            state_nx_s = ST_FULL;
            buf_ld_s   = 1'b1;
          end
        end else if (underrun_ev_s) begin
          stale_nx_s = 1'b1;
        end else begin
          stale_nx_s = stale_r;
        end
      end
      ST_FULL: begin
        req_nx_s = 1'b0;
        if (load_s || row_end_s) begin
          state_nx_s = ST_IDLE;
        end else begin
          state_nx_s = ST_FULL;
        end
      end
      default: begin
        state_nx_s = ST_IDLE;
        req_nx_s   = 1'b0;
        addr_nx_s  = {ADDR_WIDTH{1'b0}};
        stale_nx_s = 1'b0;
      end
    endcase
  end

  // FSM state and registered read-port outputs.
  always_ff @(posedge CLK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      state_r     <= ST_IDLE;
      mem_rd_req  <= 1'b0;
      mem_rd_addr <= {ADDR_WIDTH{1'b0}};
      stale_r     <= 1'b0;
    end else begin
      state_r     <= state_nx_s;
      mem_rd_req  <= req_nx_s;
      mem_rd_addr <= addr_nx_s;
      stale_r     <= stale_nx_s;
    end
  end

  // One-word prefetch buffer.
  always_ff @(posedge CLK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      buf_r <= {DATA_WIDTH{1'b0}};
    end else if (buf_ld_s) begin
      buf_r <= mem_rd_data;
    end
  end

  // Prefetch target: steps along the row on each load, jumps to the next line at row end.
  always_ff @(posedge CLK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      tline_r <= 10'd0;
      tcol_r  <= {COL_W{1'b0}};
      pend_r  <= 1'b0;
    end else if (row_end_s) begin
      tline_r <= nline_s;
      tcol_r  <= {COL_W{1'b0}};
      pend_r  <= 1'b1;
    end else if (load_s) begin
      if (col_more_s) begin
        tcol_r <= col_next_s;
        pend_r <= 1'b1;
      end else begin
        pend_r <= 1'b0;
      end
    end else if (issue_s) begin
      pend_r <= 1'b0;
    end
  end

  // Display word and sticky underrun flag.
  always_ff @(posedge CLK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      pixel_in <= {DATA_WIDTH{1'b0}};
      underrun <= 1'b0;
    end else begin
      if (row_end_s) begin
        pixel_in <= {DATA_WIDTH{1'b0}};
      end else if (load_s) begin
        pixel_in <= full_s ? buf_r : {DATA_WIDTH{1'b0}};
      end
      if (underrun_ev_s) begin
        underrun <= 1'b1;
      end
    end
  end

`ifdef VGA_FETCH_UNDERRUN_CNT_EN
  logic frame_start_s;
  assign frame_start_s = (pixel_x == 10'd0) && (pixel_y == 10'd0);

  // Per-frame saturating underrun counter.
  always_ff @(posedge CLK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      underrun_cnt <= 8'd0;
    end else if (frame_start_s) begin
      underrun_cnt <= underrun_ev_s ? 8'd1 : 8'd0;
    end else if (underrun_ev_s && (underrun_cnt != 8'hFF)) begin
      underrun_cnt <= underrun_cnt + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_vga_fetch.sv
// Directed bench for vga_fetch: drives scan positions and plays the memory arbiter/responder.
module tb_vga_fetch;

  logic        CLK_50;
  logic        RESET_N;
  logic [9:0]  pixel_x;
  logic [9:0]  pixel_y;
  logic        mem_rd_req;
  logic [7:0]  mem_rd_addr;
  logic        mem_rd_gnt;
  logic        mem_rd_valid;
  logic [15:0] mem_rd_data;
  logic [15:0] pixel_in;
  logic        underrun;
`ifdef VGA_FETCH_UNDERRUN_CNT_EN
  logic [7:0]  underrun_cnt;
`endif

  int          n_tests;
  int          n_fail;
  logic        gnt_en;
  logic        vhold;
  logic        pend_v;
  int          vcnt;
  logic [15:0] pdata;
  logic [7:0]  log_addr [0:15];
  int          log_y    [0:15];
  int          req_n;

  vga_fetch dut (
    .CLK_50       (CLK_50),
    .RESET_N      (RESET_N),
    .pixel_x      (pixel_x),
    .pixel_y      (pixel_y),
    .mem_rd_req   (mem_rd_req),
    .mem_rd_addr  (mem_rd_addr),
    .mem_rd_gnt   (mem_rd_gnt),
    .mem_rd_valid (mem_rd_valid),
    .mem_rd_data  (mem_rd_data),
    .pixel_in     (pixel_in),
`ifdef VGA_FETCH_UNDERRUN_CNT_EN
    .underrun_cnt (underrun_cnt),
`endif
    .underrun     (underrun)
  );

  // 50 MHz-style free-running clock.
  initial CLK_50 = 1'b0;
  always #5 CLK_50 = ~CLK_50;

  function automatic logic [15:0] dword(input logic [7:0] a);
    return {8'hA5, a};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_log();
    req_n = 0;
    for (int i = 0; i < 16; i++) begin
      log_addr[i] = 8'hFF;
      log_y[i]    = -1;
    end
  endtask

  // One clock: present position, answer the read port, advance to the next falling edge.
  task automatic cyc(input int x, input int y);
    pixel_x      = 10'(x);
    pixel_y      = 10'(y);
    mem_rd_valid = 1'b0;
    mem_rd_data  = 16'hDEAD;
    if (pend_v) begin
      if (vcnt > 0) vcnt--;
      if (vcnt == 0 && !vhold) begin
        mem_rd_valid = 1'b1;
        mem_rd_data  = pdata;
        pend_v       = 1'b0;
      end
    end
    mem_rd_gnt = gnt_en && mem_rd_req;
    if (mem_rd_gnt) begin
      pend_v = 1'b1;
      vcnt   = 2;
      pdata  = dword(mem_rd_addr);
      if (req_n < 16) begin
        log_addr[req_n] = mem_rd_addr;
        log_y[req_n]    = y;
      end
      req_n++;
    end
    @(posedge CLK_50);
    @(negedge CLK_50);
  endtask

  task automatic scan(input int y, input int x0, input int x1);
    for (int x = x0; x <= x1; x++) cyc(x, y);
  endtask

  initial begin
    n_tests      = 0;
    n_fail       = 0;
    gnt_en       = 1'b1;
    vhold        = 1'b0;
    pend_v       = 1'b0;
    vcnt         = 0;
    pdata        = 16'h0000;
    RESET_N      = 1'b0;
    pixel_x      = 10'd400;
    pixel_y      = 10'd14;
    mem_rd_gnt   = 1'b0;
    mem_rd_valid = 1'b0;
    mem_rd_data  = 16'h0000;
    clear_log();

    repeat (3) @(negedge CLK_50);
    chk("rst_req", {31'd0, mem_rd_req}, 32'd0);
    chk("rst_addr", {24'd0, mem_rd_addr}, 32'd0);
    chk("rst_pix", {16'd0, pixel_in}, 32'd0);
    chk("rst_unr", {31'd0, underrun}, 32'd0);
    RESET_N = 1'b1;

    // no target pending until the row end of line 14
    scan(14, 400, 510);
    chk("idle_req", {31'd0, mem_rd_req}, 32'd0);
    chk("idle_nreq", req_n, 0);
    scan(14, 511, 799);
    chk("l15_first_addr", {24'd0, log_addr[0]}, 32'd0);
    chk("l15_x0", {16'd0, pixel_in}, {16'd0, dword(8'd0)});

    scan(15, 0, 126);
    chk("l15_x126", {16'd0, pixel_in}, {16'd0, dword(8'd0)});
    cyc(127, 15);
    chk("l15_x128", {16'd0, pixel_in}, {16'd0, dword(8'd1)});
    scan(15, 128, 255);
    chk("l15_x256", {16'd0, pixel_in}, {16'd0, dword(8'd2)});
    scan(15, 256, 383);
    chk("l15_x384", {16'd0, pixel_in}, {16'd0, dword(8'd3)});
    scan(15, 384, 399);
    clear_log();
    scan(15, 400, 511);
    chk("l15_x512", {16'd0, pixel_in}, 32'd0);
    scan(15, 512, 799);
    chk("l16_x0", {16'd0, pixel_in}, {16'd0, dword(8'd4)});
    scan(16, 0, 127);
    chk("l16_x128", {16'd0, pixel_in}, {16'd0, dword(8'd5)});
    scan(16, 128, 255);
    chk("l16_x256", {16'd0, pixel_in}, {16'd0, dword(8'd6)});
    scan(16, 256, 383);
    chk("l16_x384", {16'd0, pixel_in}, {16'd0, dword(8'd7)});
    scan(16, 384, 500);
    chk("l16_nreq", req_n, 4);
    for (int i = 0; i < 4; i++) chk($sformatf("l16_addr%0d", i), {24'd0, log_addr[i]}, 32'(4 + i));
    chk("l16_unr", {31'd0, underrun}, 32'd0);
    scan(16, 501, 799);
    chk("l17_x0", {16'd0, pixel_in}, {16'd0, dword(8'd4)});

    // grant withheld across the x=127 deadline
    gnt_en = 1'b0;
    scan(17, 0, 127);
    chk("gnt_lo_pix", {16'd0, pixel_in}, 32'd0);
    chk("gnt_lo_unr", {31'd0, underrun}, 32'd1);
    gnt_en = 1'b1;
    scan(17, 128, 200);
    chk("gnt_lo_x200", {16'd0, pixel_in}, 32'd0);
    scan(17, 201, 255);
    chk("gnt_lo_x256", {16'd0, pixel_in}, {16'd0, dword(8'd6)});
    scan(17, 256, 799);
    chk("l18_x0", {16'd0, pixel_in}, {16'd0, dword(8'd4)});

    // return coincides with the x=255 consume
    scan(18, 0, 127);
    chk("l18_x128", {16'd0, pixel_in}, {16'd0, dword(8'd5)});
    vhold = 1'b1;
    scan(18, 128, 254);
    vhold = 1'b0;
    cyc(255, 18);
    chk("vld_cons_pix", {16'd0, pixel_in}, 32'd0);
    scan(18, 256, 383);
    chk("vld_cons_x384", {16'd0, pixel_in}, {16'd0, dword(8'd7)});
    chk("unr_sticky", {31'd0, underrun}, 32'd1);
    scan(18, 384, 450);

    // bottom of the memory area and the wrap to line 0
    clear_log();
    scan(382, 451, 799);
    chk("l383_x0", {16'd0, pixel_in}, {16'd0, dword(8'd92)});
    scan(383, 0, 383);
    chk("l383_x384", {16'd0, pixel_in}, {16'd0, dword(8'd95)});
    scan(383, 384, 511);
    chk("l383_x512", {16'd0, pixel_in}, 32'd0);
    scan(383, 512, 799);
    chk("l384_x0", {16'd0, pixel_in}, 32'd0);
    chk("l383_nreq", req_n, 4);
    chk("l383_addr0", {24'd0, log_addr[0]}, 32'd92);
    chk("l383_addr3", {24'd0, log_addr[3]}, 32'd95);
    scan(384, 0, 799);
    scan(523, 0, 799);
    chk("blank_nreq", req_n, 4);
    chk("blank_req", {31'd0, mem_rd_req}, 32'd0);
    scan(524, 0, 799);
    chk("l524_nreq", req_n, 5);
    chk("l524_addr", {24'd0, log_addr[4]}, 32'd0);
    chk("l524_y", log_y[4], 524);
    chk("l0_x0", {16'd0, pixel_in}, {16'd0, dword(8'd0)});

    // reset while a request is pending, then a late return
    gnt_en = 1'b0;
    scan(0, 0, 5);
    chk("mid_req", {31'd0, mem_rd_req}, 32'd1);
    chk("mid_addr", {24'd0, mem_rd_addr}, 32'd1);
    RESET_N = 1'b0;
    #1;
    chk("async_req", {31'd0, mem_rd_req}, 32'd0);
    chk("async_pix", {16'd0, pixel_in}, 32'd0);
    chk("async_unr", {31'd0, underrun}, 32'd0);
    @(negedge CLK_50);
    RESET_N = 1'b1;
    gnt_en  = 1'b1;
    pend_v  = 1'b1;
    vcnt    = 1;
    pdata   = 16'h1234;
    scan(0, 6, 126);
    chk("late_req", {31'd0, mem_rd_req}, 32'd0);
    cyc(127, 0);
    chk("late_pix", {16'd0, pixel_in}, 32'd0);
    chk("late_unr", {31'd0, underrun}, 32'd1);

`ifdef VGA_FETCH_UNDERRUN_CNT_EN
    chk("cnt_one", {24'd0, underrun_cnt}, 32'd1);
    gnt_en = 1'b0;
    repeat (300) cyc(127, 0);
    chk("cnt_sat", {24'd0, underrun_cnt}, 32'd255);
    cyc(0, 0);
    chk("cnt_clr", {24'd0, underrun_cnt}, 32'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/vga_fetch.md
Name: vga_fetch

Overview:
- Memory-side reader that supplies the `pixel_in` word consumed by the VGA display path.
- Tracks `pixel_x`/`pixel_y` from the sync generator and prefetches one framebuffer word ahead over a req/gnt/valid read port shared with the CPU.
- Presents each word to the display exactly on the clock edge where `pixel_x` enters that word's screen span.
- Flags underruns when memory does not return a word in time.

Parameters:
- DATA_WIDTH, 16, bits per framebuffer word (memory pixels per word).
- ADDR_WIDTH, 8, word address width.
- BITS_PER_MEMORY_PIXEL_X, 3, log2 of screen pixels per memory pixel horizontally.
- BITS_PER_MEMORY_PIXEL_Y, 4, log2 of screen lines per memory pixel vertically.
- HEX_START_X, 512, first screen column outside the memory area.
- AREA_H, 384, first screen line outside the memory area.
- H_LAST, 799, last `pixel_x` value of a line.
- V_LAST, 524, last `pixel_y` value of a frame.
- BASE_ADDR, 0, word address of memory pixel (0,0).

Ports:
- CLK_50  in  1  system clock.
- RESET_N  in  1  reset, asynchronous, active-low.
- pixel_x  in  10  current column from the sync generator.
- pixel_y  in  10  current line from the sync generator.
- mem_rd_req  out  1  read request, held high until granted.
- mem_rd_addr  out  ADDR_WIDTH  read word address, stable while `mem_rd_req` is high.
- mem_rd_gnt  in  1  arbiter grant; request accepted on a cycle where `mem_rd_req` and `mem_rd_gnt` are both high.
- mem_rd_valid  in  1  read data valid, one cycle, at least 1 cycle after grant.
- mem_rd_data  in  DATA_WIDTH  read data.
- pixel_in  out  DATA_WIDTH  word for the current `pixel_x`, registered.
- underrun  out  1  sticky underrun flag, cleared only by reset.

Behaviour:
Derived constants:
- PPW = 2^(clog2(DATA_WIDTH)+BITS_PER_MEMORY_PIXEL_X), i.e. screen pixels per word.
- WPR = HEX_START_X / PPW, i.e. words per row.

Reset and address arithmetic:
- Reset values: `mem_rd_req`=0, `mem_rd_addr`=0, `pixel_in`=0, `underrun`=0; buffer empty; FSM in IDLE.
- Address = BASE_ADDR + mrow*WPR + col, where mrow = line >> BITS_PER_MEMORY_PIXEL_Y.
- Address arithmetic is ADDR_WIDTH wide and wraps modulo 2^ADDR_WIDTH.

Target line and prefetch:
- nline = 0 if `pixel_y`==V_LAST, else `pixel_y`+1.
- The prefetch target is (tline, tcol).
- The target advances col+1 after each consume while col+1 < WPR.
- Otherwise the target becomes the next line, col 0, activated at the row-end event.
- No fetch is issued for a target line >= AREA_H.

FSM, one-word buffer:
- IDLE: if a target is pending and the buffer is empty, go to REQ with `mem_rd_addr` = target address and `mem_rd_req`=1.
- REQ: hold `req`/`addr`; on `gnt`, drop `req` next cycle and go to WAIT.
- WAIT: on `mem_rd_valid`, capture `mem_rd_data` into the buffer and go to FULL.
- FULL: hold until a consume event, then go to IDLE.
- `mem_rd_valid` outside WAIT is ignored.

Consume events, evaluated on the current `pixel_x`/`pixel_y`; `pixel_in` updates on the same edge that `pixel_x` advances:
- Word boundary: `pixel_x` % PPW == PPW-1, `pixel_x` < HEX_START_X-1, `pixel_y` < AREA_H. Load next word.
- Row end: `pixel_x` == HEX_START_X-1. `pixel_in` <= 0; target becomes (nline, 0).
- Line start: `pixel_x` == H_LAST, nline < AREA_H. Load the word for (nline, col 0).
- "Load" means `pixel_in` <= buffer and the buffer empties.

Underrun handling, when a load event occurs while the FSM is not in FULL:
- `pixel_in` <= 0 and `underrun` <= 1.
- Any outstanding request or return is marked stale: its data is discarded on arrival and the FSM returns to IDLE.
- The target still advances, so the following word is fetched normally.
- Display stays aligned; only the missed word is black.

Simultaneous events:
- A consume on the same cycle as `mem_rd_valid` in WAIT counts as an underrun; the returning data is discarded.
- Grant and consume on the same cycle: the request is accepted and the FSM proceeds to WAIT.

Reset mid-operation:
- `req` drops immediately (asynchronously); all state returns to reset values.
- A late `mem_rd_valid` after reset is ignored because the FSM is not in WAIT.

Optional Feature:
- Macro: VGA_FETCH_UNDERRUN_CNT_EN.
- Defined: adds output `underrun_cnt` [7:0], reset 0.
  - Increments on each underrun event and saturates at 255.
  - Cleared when `pixel_x`==0 and `pixel_y`==0 (frame start), unless an underrun occurs that cycle, in which case it is set to 1.
- Undefined: port absent; only the sticky `underrun` flag exists.

Test Plan:
- Reset with `pixel_x`/`pixel_y` at mid-line, then release -> all outputs 0, no `mem_rd_req` until a target line < 384 is pending.
- Defaults (PPW=128, WPR=4); `gnt` same cycle as `req`; `valid` 2 cycles after grant; sweep line y=15 into y=16 -> addresses 4,5,6,7 requested for line 16. `pixel_in` changes to the word at addr 4 on the edge where `pixel_x` goes 799->0, then to addr 5 at 127->128, and so on. `pixel_in`=0 from x=512.
- Line y=383 into 384 -> no requests issued for lines 384..524. The request for line 0, addr 0, is issued during line 524.
- Hold `mem_rd_gnt` low across x=127 -> `pixel_in`=0 for x=128..255 and `underrun`=1. The late data is discarded; the word for x=256 is fetched and displayed correctly.
- `mem_rd_valid` asserted on the same cycle as the x=255 consume -> treated as underrun and the data is discarded.
- With VGA_FETCH_UNDERRUN_CNT_EN: force 300 underruns in one frame -> `underrun_cnt`=255. At frame start with no underrun -> `underrun_cnt`=0.
